// File: rtl/tf_display_mux_pkg.sv
// Shared constants for the traffic-light display path: timer width, light bit
// positions, conversion FSM states and the active-low 7-segment digit decode.
package tf_display_mux_pkg;

  localparam int TIMER_W     = 7;
  localparam int SAT_MAX_DEF = 99;

  localparam int TF_RED = 2;
  localparam int TF_YEL = 1;
  localparam int TF_GRN = 0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SNAP   = 2'd0,
    CONV0  = 2'd1,
    CONV1  = 2'd2,
    COMMIT = 2'd3
  } conv_state_e;

  // Segment order {g,f,e,d,c,b,a}, a driven 0 lights the segment
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic tf_valid(input logic [2:0] tf);
    return (tf == 3'(1 << TF_RED)) || (tf == 3'(1 << TF_YEL)) ||
           (tf == 3'(1 << TF_GRN));
  endfunction

endpackage

// File: rtl/tf_display_mux_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one bit per cycle, result
// valid on done_o exactly TIMER_W cycles after the start_i cycle.
module tf_display_mux_bin2bcd_seq
  import tf_display_mux_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [TIMER_W-1:0] bin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [7:0]         bcd_o
);

  localparam int SR_W = 8 + TIMER_W;

  logic [SR_W-1:0] sr_q;
  logic [2:0]      cnt_q;
  logic            done_q;

  // Adjust each BCD nibble that would overflow on doubling, then shift in one bit
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    if (t[TIMER_W+3 -: 4] >= 4'd5) t[TIMER_W+3 -: 4] = t[TIMER_W+3 -: 4] + 4'd3;
    if (t[SR_W-1 -: 4] >= 4'd5)    t[SR_W-1 -: 4]    = t[SR_W-1 -: 4] + 4'd3;
    return {t[SR_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q   <= '0;
      cnt_q  <= 3'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        sr_q  <= dabble_step({8'h00, bin_i});
        cnt_q <= 3'(TIMER_W - 1);
      end else if (cnt_q != 3'd0) begin
        sr_q   <= dabble_step(sr_q);
        cnt_q  <= cnt_q - 3'd1;
        done_q <= (cnt_q == 3'd1);
      end
    end
  end

  assign busy_o = (cnt_q != 3'd0);
  assign done_o = done_q;
  assign bcd_o  = sr_q[SR_W-1 -: 8];

endmodule

// File: rtl/tf_display_mux.sv
// Traffic-light display stage: time-shared BCD conversion of both countdowns,
// 4-digit multiplexed 7-segment scan and registered RYG lamp outputs.
module tf_display_mux
  import tf_display_mux_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned SAT_MAX  = SAT_MAX_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [TIMER_W-1:0] TIMER0,
  input  logic [2:0]         TF0,
  input  logic [TIMER_W-1:0] TIMER1,
  input  logic [2:0]         TF1,
  output logic [6:0]         SEG,
  output logic [3:0]         AN,
  output logic [2:0]         LED0,
  output logic [2:0]         LED1,
  output logic               ERR
);

  localparam int               DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]       LAST_STEP = 3'(TIMER_W - 1);

  conv_state_e        state_q;
  logic [2:0]         step_q;
  logic               start_q;
  logic [TIMER_W-1:0] snap0_q, snap1_q;
  logic [7:0]         bcd0_q, disp0_q, disp1_q;

  logic               b2b_busy, b2b_done;
  logic [7:0]         b2b_bcd;
  logic [TIMER_W-1:0] b2b_bin;

  logic [DIV_W-1:0]   div_q;
  logic [1:0]         dig_q, dig_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic [2:0]         led0_q, led1_q;
  logic               err_q;

  function automatic logic [TIMER_W-1:0] sat_timer(input logic [TIMER_W-1:0] t);
    return (32'(t) > SAT_MAX) ? TIMER_W'(SAT_MAX) : t;
  endfunction

  function automatic logic [6:0] tens_seg(input logic [3:0] bcd);
    return (bcd == 4'd0) ? SEG_BLANK : seg_decode(bcd);
  endfunction

  assign b2b_bin = (state_q == CONV1) ? snap1_q : snap0_q;

  tf_display_mux_bin2bcd_seq u_bin2bcd (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .start_i (start_q & ~b2b_busy),
    .bin_i   (b2b_bin),
    .busy_o  (b2b_busy),
    .done_o  (b2b_done),
    .bcd_o   (b2b_bcd)
  );

  // Conversion loop: 1 SNAP + 7 CONV0 + 7 CONV1 + 1 COMMIT = 16 cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SNAP;
      step_q  <= 3'd0;
      start_q <= 1'b0;
      snap0_q <= '0;
      snap1_q <= '0;
      bcd0_q  <= 8'h00;
      disp0_q <= 8'h00;
      disp1_q <= 8'h00;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        SNAP: begin
          snap0_q <= sat_timer(TIMER0);
          snap1_q <= sat_timer(TIMER1);
          start_q <= 1'b1;
          step_q  <= 3'd0;
          state_q <= CONV0;
        end
        CONV0: begin
          if (step_q == LAST_STEP) begin
            step_q  <= 3'd0;
            start_q <= 1'b1;
            state_q <= CONV1;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        CONV1: begin
          if (b2b_done) bcd0_q <= b2b_bcd;
          if (step_q == LAST_STEP) begin
            step_q  <= 3'd0;
            state_q <= COMMIT;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        COMMIT: begin
          disp0_q <= bcd0_q;
          disp1_q <= b2b_bcd;
          state_q <= SNAP;
        end
      endcase
    end
  end

  always_comb begin
    dig_d = dig_q + 2'd1;
    an_d  = ~(4'b0001 << dig_d);
    case (dig_d)
      2'd0:    seg_d = seg_decode(disp0_q[3:0]);
      2'd1:    seg_d = tens_seg(disp0_q[7:4]);
      2'd2:    seg_d = seg_decode(disp1_q[3:0]);
      default: seg_d = tens_seg(disp1_q[7:4]);
    endcase
  end

  // Digit index parks at 3 so the first terminal count lights digit 0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q <= '0;
      dig_q <= 2'd3;
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      dig_q <= dig_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led0_q <= 3'b000;
      led1_q <= 3'b000;
      err_q  <= 1'b0;
    end else begin
      led0_q <= tf_valid(TF0) ? TF0 : 3'b000;
      led1_q <= tf_valid(TF1) ? TF1 : 3'b000;
      err_q  <= ~(tf_valid(TF0) & tf_valid(TF1));
    end
  end

  assign SEG  = seg_q;
  assign AN   = an_q;
  assign LED0 = led0_q;
  assign LED1 = led1_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_tf_display_mux.sv
// Bench for tf_display_mux: cycle-count reference model compared every cycle,
// plus directed literal checks of reset, digits, saturation, lamps and resets.
module tb_tf_display_mux;

  localparam int SD = 4;
  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] TIMER0, TIMER1;
  logic [2:0] TF0, TF1;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic [2:0] LED0, LED1;
  logic       ERR;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  tf_display_mux #(.SCAN_DIV(SD), .SAT_MAX(99)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .TIMER0 (TIMER0),
    .TF0    (TF0),
    .TIMER1 (TIMER1),
    .TF1    (TF1),
    .SEG    (SEG),
    .AN     (AN),
    .LED0   (LED0),
    .LED1   (LED1),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: everything derived from the edge count since reset release
  int         cyc = 0, snap0_m = 0, snap1_m = 0, disp0_m = 0, disp1_m = 0;
  logic [6:0] seg_m = 7'h7F;
  logic [3:0] an_m = 4'hF;
  logic [2:0] led0_m = 3'b000, led1_m = 3'b000;
  logic       err_m = 1'b0;

  function automatic bit one_hot(input logic [2:0] t);
    return (t == 3'b001) || (t == 3'b010) || (t == 3'b100);
  endfunction

  function automatic logic [6:0] digit_seg(input int d);
    int v, n;
    v = (d < 2) ? disp0_m : disp1_m;
    n = (d % 2 == 0) ? (v % 10) : (v / 10);
    if ((d % 2 == 1) && (n == 0)) return 7'h7F;
    return PAT[n];
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc = 0; snap0_m = 0; snap1_m = 0; disp0_m = 0; disp1_m = 0;
      seg_m = 7'h7F; an_m = 4'hF; led0_m = 3'b000; led1_m = 3'b000; err_m = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (cyc % SD == 0) begin
        an_m  = ~(4'b0001 << ((cyc / SD - 1) % 4));
        seg_m = digit_seg((cyc / SD - 1) % 4);
      end
      if (cyc % 16 == 1) begin
        snap0_m = (TIMER0 > 7'd99) ? 99 : int'(TIMER0);
        snap1_m = (TIMER1 > 7'd99) ? 99 : int'(TIMER1);
      end else if (cyc % 16 == 0) begin
        disp0_m = snap0_m;
        disp1_m = snap1_m;
      end
      led0_m = one_hot(TF0) ? TF0 : 3'b000;
      led1_m = one_hot(TF1) ? TF1 : 3'b000;
      err_m  = !(one_hot(TF0) && one_hot(TF1));
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_SEG",  32'(SEG),  32'(seg_m));
      check("model_AN",   32'(AN),   32'(an_m));
      check("model_LED0", 32'(LED0), 32'(led0_m));
      check("model_LED1", 32'(LED1), 32'(led1_m));
      check("model_ERR",  32'(ERR),  32'(err_m));
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_SEG"},  32'(SEG),  32'h7F);
    check({tag, "_AN"},   32'(AN),   32'hF);
    check({tag, "_LED0"}, 32'(LED0), 32'h0);
    check({tag, "_LED1"}, 32'(LED1), 32'h0);
    check({tag, "_ERR"},  32'(ERR),  32'h0);
  endtask

  task automatic release_and_check(input string tag);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1 check({tag, "_an_pre_tc"}, 32'(AN), 32'hF);
    @(posedge CLK);
    #1 check({tag, "_an_first_tc"}, 32'(AN), 32'hE);
  endtask

  task automatic read_digit(input int d, output logic [6:0] s);
    logic [3:0] tgt;
    bit found;
    tgt = ~(4'b0001 << d);
    found = 1'b0;
    s = 7'h7F;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (AN == tgt) begin
        found = 1'b1;
        s = SEG;
      end
    end
    if (!found) check("digit_wait_timeout", 32'(AN), 32'(tgt));
  endtask

  task automatic wait_cyc_mod16(input int m);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge CLK);
      if (cyc % 16 == m) hit = 1'b1;
    end
    if (!hit) check("phase_wait_timeout", 32'(cyc % 16), 32'(m));
  endtask

  initial begin
    logic [6:0] s;
    logic [3:0] prev;
    bit         found;
    int         bvals [8] = '{0, 9, 10, 98, 99, 100, 127, 55};

    RST_N = 1'b0;
    TIMER0 = 7'd0; TIMER1 = 7'd0;
    TF0 = 3'b001; TF1 = 3'b100;
    #7 cmp_en = 1'b1;
    #20;
    check_reset_outputs("rst");
    release_and_check("rel1");

    // Two-timer conversion and scan order
    @(negedge CLK); TIMER0 = 7'd42; TIMER1 = 7'd7;
    repeat (48) @(negedge CLK);
    read_digit(0, s); check("t42_units", 32'(s), 32'h24);
    read_digit(1, s); check("t42_tens",  32'(s), 32'h19);
    read_digit(2, s); check("t7_units",  32'(s), 32'h78);
    read_digit(3, s); check("t7_tens",   32'(s), 32'h7F);
    found = 1'b0;
    prev = AN;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (AN == 4'hE && prev != 4'hE) found = 1'b1;
      prev = AN;
    end
    if (!found) check("an_seq_timeout", 32'(AN), 32'hE);
    repeat (SD) @(negedge CLK); check("an_seq_1", 32'(AN), 32'hD);
    repeat (SD) @(negedge CLK); check("an_seq_2", 32'(AN), 32'hB);
    repeat (SD) @(negedge CLK); check("an_seq_3", 32'(AN), 32'h7);
    repeat (SD) @(negedge CLK); check("an_seq_4", 32'(AN), 32'hE);

    // Saturation and blanking boundaries
    @(negedge CLK); TIMER0 = 7'd127; TIMER1 = 7'd0;
    repeat (48) @(negedge CLK);
    read_digit(0, s); check("sat_units", 32'(s), 32'h10);
    read_digit(1, s); check("sat_tens",  32'(s), 32'h10);
    read_digit(2, s); check("zero_units", 32'(s), 32'h40);
    read_digit(3, s); check("zero_tens",  32'(s), 32'h7F);
    @(negedge CLK); TIMER0 = 7'd10;
    repeat (48) @(negedge CLK);
    read_digit(0, s); check("ten_units", 32'(s), 32'h40);
    read_digit(1, s); check("ten_tens",  32'(s), 32'h79);

    // Input change in the middle of CONV1
    @(negedge CLK); TIMER0 = 7'd30;
    repeat (48) @(negedge CLK);
    read_digit(0, s); check("coh30_units", 32'(s), 32'h40);
    read_digit(1, s); check("coh30_tens",  32'(s), 32'h30);
    wait_cyc_mod16(11);
    TIMER0 = 7'd29;
    repeat (48) @(negedge CLK);
    read_digit(0, s); check("coh29_units", 32'(s), 32'h10);
    read_digit(1, s); check("coh29_tens",  32'(s), 32'h24);

    // Lamps and error flag
    @(negedge CLK); TF0 = 3'b100; TF1 = 3'b001;
    @(negedge CLK);
    check("led0_red", 32'(LED0), 32'h4);
    check("led1_grn", 32'(LED1), 32'h1);
    check("err_clear", 32'(ERR), 32'h0);
    @(negedge CLK); TF1 = 3'b011;
    @(posedge CLK);
    #1 check("led1_bad", 32'(LED1), 32'h0);
    check("err_set", 32'(ERR), 32'h1);
    check("led0_kept", 32'(LED0), 32'h4);
    @(negedge CLK); TF1 = 3'b001;
    @(negedge CLK);
    check("led1_back", 32'(LED1), 32'h1);
    check("err_back", 32'(ERR), 32'h0);

    // Async reset during CONV0, then during digit 2 of the scan
    wait_cyc_mod16(3);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("rst_conv0");
    #27;
    release_and_check("rel2");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (AN == 4'hB) found = 1'b1;
    end
    if (!found) check("digit2_wait_timeout", 32'(AN), 32'hB);
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("rst_dig2");
    #27;
    release_and_check("rel3");

    // Randomized traffic with boundary-biased timer values
    for (int i = 0; i < 700; i++) begin
      @(negedge CLK);
      if ($urandom_range(9) == 0)
        TIMER0 = ($urandom_range(1) == 0) ? 7'(bvals[$urandom_range(7)]) : 7'($urandom_range(127));
      if ($urandom_range(9) == 0)
        TIMER1 = ($urandom_range(1) == 0) ? 7'(bvals[$urandom_range(7)]) : 7'($urandom_range(127));
      if ($urandom_range(15) == 0) TF0 = 3'($urandom_range(7));
      else if ($urandom_range(7) == 0) TF0 = 3'b001 << $urandom_range(2);
      if ($urandom_range(15) == 0) TF1 = 3'($urandom_range(7));
      else if ($urandom_range(7) == 0) TF1 = 3'b001 << $urandom_range(2);
    end

    repeat (2) @(negedge CLK);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
